mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   Load/store sequencer between the pipeline MEM stage and the byte-addressed
//   16-bit data memory (2-byte write per op, synchronous read, 1-cycle latency).
//   Accepts one request at a time; performs word load/store, byte load with
//   sign/zero extension, and byte store by read-modify-write.
//   Pulses out_done with result; drives the memory's address/data/enable pins.
// PARAMETERS
//   ADDR_W     16    address width (pipeline and memory side)
//   DATA_W     16    data word width; byte lane = [7:0]
//   MEM_BYTES  1024  memory size in bytes; used only by the range check
// PORTS
//   inp_clk            in   1       clock, all state on rising edge
//   inp_rst            in   1       asynchronous, active-high reset
//   inp_req            in   1       request valid; accepted only when out_ready=1
//   inp_we             in   1       1=store, 0=load
//   inp_byte           in   1       1=byte access, 0=word access
//   inp_signed         in   1       byte load: 1=sign-extend, 0=zero-extend
//   inp_addr           in   ADDR_W  byte address
//   inp_wdata          in   DATA_W  store data (byte store uses [7:0])
//   out_ready          out  1       unit idle, request accepted this edge if inp_req=1
//   out_done           out  1       1-cycle completion pulse
//   out_rdata          out  DATA_W  load result, valid while out_done=1, held after
//   out_err            out  1       alignment/range error, valid with out_done
//   out_mem_address    out  ADDR_W  to memory address
//   out_mem_dataWrite  out  DATA_W  to memory write data
//   out_mem_memRead    out  1       to memory read enable
//   out_mem_memWrite   out  1       to memory write enable
//   inp_mem_read       in   DATA_W  from memory read data (registered in memory)
// BEHAVIOUR
//   - Reset (async): state=IDLE; req regs, out_rdata, out_err, out_done = 0;
//     memRead/memWrite = 0 immediately (decoded from state); out_ready=1 after.
//   - Accept: inp_req & out_ready at edge E0 latches we/byte/signed/addr/wdata.
//     inp_req while busy ignored, not queued. Latched values drive memory pins,
//     held stable for the whole op.
//   - FSM: IDLE, RD, CAP, WR, DONE. out_ready=1 only in IDLE; out_done=1 only in DONE.
//     Word load : IDLE->RD->CAP->DONE. RD asserts memRead; CAP samples
//                 inp_mem_read at its closing edge into out_rdata. done 3 cyc after E0.
//     Byte load : same path; out_rdata = ext(inp_mem_read[7:0]) by inp_signed.
//     Word store: IDLE->WR->DONE. WR asserts memWrite, dataWrite=wdata. 2 cycles.
//     Byte store: IDLE->RD->CAP->WR->DONE. CAP captures word at addr; WR writes
//                 {captured[15:8], wdata[7:0]} at addr. Other byte unchanged. 4 cyc.
//     DONE -> IDLE unconditionally next edge.
//   - memRead and memWrite never both 1; both 0 in IDLE, CAP, DONE.
//   - Stores leave out_rdata unchanged. out_err=0 on every completion w/o macro.
//   - Address arithmetic: no alignment required; addr+1 byte fetch done by memory.
//   - Reset mid-op: op abandoned; write in WR not performed if reset precedes edge.
// CONFIGURATION
//   MEM_ALIGN_CHECK_EN defined: word access with addr[0]=1, or any access with
//     addr+(byte?0:1) >= MEM_BYTES, goes IDLE->DONE with out_err=1, no
//     memRead/memWrite asserted, out_rdata unchanged. Byte access never misaligned.
//   Not defined: no check, out_err tied 0, all requests forwarded to memory.
// TESTING
//   - Reset mid byte-store (in WR) -> memWrite drops same cycle, memory byte unchanged, out_ready=1.
//   - Word store 0xBEEF @0x0010, word load @0x0010 -> out_rdata=0xBEEF, done 3 cyc after accept.
//   - Byte load @0x0011 (mem=0x80) signed -> 0xFF80; unsigned -> 0x0080.
//   - Byte store 0x5A @0x0010 over 0xBEEF -> word load @0x0010 = 0xBE5A; @0x0011 byte=0xBE.
//   - inp_req held high during busy load -> second request taken only after DONE, one op each.
//   - MEM_ALIGN_CHECK_EN: word load @0x0003 -> out_err=1 with out_done 1 cyc after accept, no memRead; @0x03FF byte ok.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response and memory-side pins of mem_access_unit.
interface mem_access_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              inp_req;
  logic              inp_we;
  logic              inp_byte;
  logic              inp_signed;
  logic [ADDR_W-1:0] inp_addr;
  logic [DATA_W-1:0] inp_wdata;
  logic              out_ready;
  logic              out_done;
  logic [DATA_W-1:0] out_rdata;
  logic              out_err;
  logic [ADDR_W-1:0] out_mem_address;
  logic [DATA_W-1:0] out_mem_dataWrite;
  logic              out_mem_memRead;
  logic              out_mem_memWrite;
  logic [DATA_W-1:0] inp_mem_read;

  modport slave (
    input  inp_req, inp_we, inp_byte, inp_signed, inp_addr, inp_wdata, inp_mem_read,
    output out_ready, out_done, out_rdata, out_err,
           out_mem_address, out_mem_dataWrite, out_mem_memRead, out_mem_memWrite
  );

  modport master (
    output inp_req, inp_we, inp_byte, inp_signed, inp_addr, inp_wdata,
    input  out_ready, out_done, out_rdata, out_err
  );

  modport mem (
    input  out_mem_address, out_mem_dataWrite, out_mem_memRead, out_mem_memWrite,
    output inp_mem_read
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer: word/byte loads, word stores, byte stores by read-modify-write.
// Optional MEM_ALIGN_CHECK_EN: misaligned/out-of-range requests complete at once with out_err.
module mem_access_unit #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_BYTES = 1024
) (
  input logic              inp_clk,
  input logic              inp_rst,
  mem_access_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t            state;
  logic              we_q;
  logic              byte_q;
  logic              signed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cap_q;
  logic [DATA_W-1:0] rdata_q;
  logic              done_q;
  logic              ready_q;
  logic              err_q;
  logic              acc_bad;
  logic [DATA_W-1:0] byte_ext;

`ifdef MEM_ALIGN_CHECK_EN
  logic [ADDR_W:0] last_byte;
  assign last_byte = {1'b0, bus.inp_addr} + {{ADDR_W{1'b0}}, ~bus.inp_byte};
  assign acc_bad   = (~bus.inp_byte & bus.inp_addr[0]) |
                     (last_byte >= (ADDR_W+1)'(MEM_BYTES));
`else
  assign acc_bad = 1'b0;
`endif

  assign byte_ext = {{(DATA_W-8){signed_q & bus.inp_mem_read[7]}}, bus.inp_mem_read[7:0]};

  always_ff @(posedge inp_clk or posedge inp_rst) begin
    if (inp_rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cap_q    <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.inp_req) begin
            we_q     <= bus.inp_we;
            byte_q   <= bus.inp_byte;
            signed_q <= bus.inp_signed;
            addr_q   <= bus.inp_addr;
            wdata_q  <= bus.inp_wdata;
            err_q    <= acc_bad;
            ready_q  <= 1'b0;
            if (acc_bad) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else if (bus.inp_we && !bus.inp_byte) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: state <= CAP;
        CAP: begin
          // Byte store keeps the fetched word private so out_rdata stays untouched.
          if (we_q) begin
            cap_q <= bus.inp_mem_read;
            state <= WR;
          end else begin
            rdata_q <= byte_q ? byte_ext : bus.inp_mem_read;
            state   <= DONE;
            done_q  <= 1'b1;
          end
        end
        WR: begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Enables decode straight from state so reset kills a pending write immediately.
  assign bus.out_mem_memRead   = (state == RD);
  assign bus.out_mem_memWrite  = (state == WR);
  assign bus.out_mem_address   = addr_q;
  assign bus.out_mem_dataWrite = byte_q ? {cap_q[DATA_W-1:8], wdata_q[7:0]} : wdata_q;
  assign bus.out_ready         = ready_q;
  assign bus.out_done          = done_q;
  assign bus.out_rdata         = rdata_q;
  assign bus.out_err           = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a little-endian byte-addressed memory model.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   n_issued = 0;

  mem_access_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_access_unit #(.ADDR_W(16), .DATA_W(16), .MEM_BYTES(1024)) dut (
    .inp_clk(clk),
    .inp_rst(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [0:1023];
  logic       mem_init = 1'b0;
  logic [9:0] ma0, ma1;
  assign ma0 = bus.out_mem_address[9:0];
  assign ma1 = ma0 + 10'd1;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i);
      mem_init <= 1'b1;
    end else begin
      if (bus.out_mem_memWrite) begin
        mem[ma0] <= bus.out_mem_dataWrite[7:0];
        mem[ma1] <= bus.out_mem_dataWrite[15:8];
      end
      if (bus.out_mem_memRead) bus.inp_mem_read <= {mem[ma1], mem[ma0]};
    end
  end

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: latency measured in cycles from the accept edge through the done cycle.
  initial begin
    int   acc_cyc = 0;
    logic rd_seen = 1'b0;
    logic wr_seen = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.out_mem_memRead && bus.out_mem_memWrite) chk("rd_wr_exclusive", 1, 0);
        if (bus.out_mem_memRead)  rd_seen = 1'b1;
        if (bus.out_mem_memWrite) wr_seen = 1'b1;
        if (bus.out_done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rdata", 32'(bus.out_rdata), 32'(e.rdata));
            chk("err", 32'(bus.out_err), 32'(e.err));
            chk("latency", 32'(cyc - acc_cyc + 1), 32'(e.lat));
            if (e.err) chk("err_no_mem_access", 32'({rd_seen, wr_seen}), 0);
          end
        end
        if (bus.out_ready && bus.inp_req) begin
          acc_cyc = cyc + 1;
          rd_seen = 1'b0;
          wr_seen = 1'b0;
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.out_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.out_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic drive(input logic we, input logic byt, input logic sgn,
                       input logic [15:0] addr, input logic [15:0] wdata);
    bus.inp_we     = we;
    bus.inp_byte   = byt;
    bus.inp_signed = sgn;
    bus.inp_addr   = addr;
    bus.inp_wdata  = wdata;
  endtask

  task automatic op(input logic we, input logic byt, input logic sgn,
                    input logic [15:0] addr, input logic [15:0] wdata,
                    input logic [15:0] rdata, input logic err, input int lat);
    exp_t e;
    wait_ready();
    e.rdata = rdata; e.err = err; e.lat = lat;
    exp_q.push_back(e);
    n_issued++;
    drive(we, byt, sgn, addr, wdata);
    bus.inp_req = 1'b1;
    @(posedge clk); #1;
    bus.inp_req = 1'b0;
  endtask

  initial begin
    int   n;
    exp_t e;
    bus.inp_req = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.out_ready), 1);
    chk("rst_done", 32'(bus.out_done), 0);
    chk("rst_rdata", 32'(bus.out_rdata), 0);
    chk("rst_err", 32'(bus.out_err), 0);
    chk("rst_mem_en", 32'({bus.out_mem_memRead, bus.out_mem_memWrite}), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Byte store interrupted by reset while in the write state.
    wait_ready();
    drive(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0099);
    bus.inp_req = 1'b1;
    @(posedge clk); #1;
    bus.inp_req = 1'b0;
    n = 0;
    while (!bus.out_mem_memWrite && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_op_reach_wr", 32'(bus.out_mem_memWrite), 1);
    rst = 1'b1;
    #1;
    chk("mid_op_wr_drop", 32'(bus.out_mem_memWrite), 0);
    chk("mid_op_ready", 32'(bus.out_ready), 1);
    chk("mid_op_done", 32'(bus.out_done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_op_mem_lo", 32'(mem[16'h20]), 32'h20);
    chk("mid_op_mem_hi", 32'(mem[16'h21]), 32'h21);

    //  we   byte sgn  addr      wdata     exp_rdata err lat
    op(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 2);
    op(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 3);
    op(1'b1, 1'b1, 1'b0, 16'h0010, 16'h335A, 16'hBEEF, 1'b0, 4);
    op(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBE5A, 1'b0, 3);
    op(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, 16'h00BE, 1'b0, 3);
    op(1'b1, 1'b1, 1'b0, 16'h0011, 16'h7780, 16'h00BE, 1'b0, 4);
    op(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, 16'hFF80, 1'b0, 3);
    op(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, 16'h0080, 1'b0, 3);
`ifdef MEM_ALIGN_CHECK_EN
    op(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, 16'h0080, 1'b1, 1);
`else
    op(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, 16'h1280, 1'b0, 3);
`endif
    op(1'b0, 1'b0, 1'b0, 16'h0012, 16'h0000, 16'h1312, 1'b0, 3);

    // Request held high across a busy load: exactly two ops, back to back.
    wait_ready();
    e.rdata = 16'h805A; e.err = 1'b0; e.lat = 3;
    exp_q.push_back(e);
    exp_q.push_back(e);
    n_issued += 2;
    drive(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
    bus.inp_req = 1'b1;
    n = 0;
    for (int k = 0; k < 40 && n < 2; k++) begin
      @(negedge clk);
      if (bus.out_ready) n++;
    end
    chk("held_req_accepts", 32'(n), 2);
    @(posedge clk); #1;
    bus.inp_req = 1'b0;

    op(1'b0, 1'b1, 1'b1, 16'h03FF, 16'h0000, 16'hFFFF, 1'b0, 3);
`ifdef MEM_ALIGN_CHECK_EN
    op(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 16'hFFFF, 1'b1, 1);
    op(1'b0, 1'b0, 1'b0, 16'h03FF, 16'h0000, 16'hFFFF, 1'b1, 1);
`else
    op(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 16'h0403, 1'b0, 3);
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    chk("done_count", 32'(done_cnt), 32'(n_issued));
    chk("mem_10", 32'(mem[16'h10]), 32'h5A);
    chk("mem_11", 32'(mem[16'h11]), 32'h80);
    chk("mem_12", 32'(mem[16'h12]), 32'h12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
